ir_cam_sequencer: RTL and testbench



---
 rtl/ir_cam_sequencer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_ir_cam_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_cam_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ir_cam_sequencer
//  Purpose  : Drives i2c_master to initialise the IR camera with a fixed
//             register table, then polls it forever: pointer write 0x36,
//             4-byte read, decode blob-1 X/Y.
//  Revision : 1.0  initial release
// ============================================================================
module ir_cam_sequencer #(
    parameter logic [6:0] I2C_ADDR      = 7'h58,
    parameter int         POWERUP_DELAY = 1000,
    parameter int         INIT_DELAY    = 1000,
    parameter int         POLL_DELAY    = 5000
) (
    input  logic       clk,
    input  logic       reset,
    output logic [6:0] i2c_addr,
    output logic [7:0] i2c_data,
    output logic [4:0] i2c_packets,
    output logic       i2c_start,
    output logic       i2c_rw,
    input  logic       i2c_ready,
    input  logic       i2c_data_req,
    input  logic       i2c_data_ready,
    input  logic [7:0] i2c_data_out,
    output logic       init_done,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       blob_valid,
    output logic       sample_strobe
);

    // ------------------------------------------------------------------
    // State and transaction-kind encodings
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ST_PWR_WAIT  = 3'd0;
    localparam logic [2:0] c_ST_ISSUE     = 3'd1;
    localparam logic [2:0] c_ST_BUSY      = 3'd2;
    localparam logic [2:0] c_ST_DONE_WAIT = 3'd3;
    localparam logic [2:0] c_ST_GAP       = 3'd4;
    localparam logic [2:0] c_ST_DECODE    = 3'd5;
    localparam logic [2:0] c_ST_POLL_WAIT = 3'd6;

    localparam logic [1:0] c_K_INIT = 2'd0;   // init-table register write
    localparam logic [1:0] c_K_PTR  = 2'd1;   // poll pointer write
    localparam logic [1:0] c_K_READ = 2'd2;   // poll 4-byte read

    localparam logic [31:0] c_PWR_LAST  = 32'(POWERUP_DELAY - 1);
    localparam logic [31:0] c_INIT_LAST = 32'(INIT_DELAY - 1);
    localparam logic [31:0] c_POLL_LAST = 32'(POLL_DELAY - 1);
    localparam logic [2:0]  c_IDX_LAST  = 3'd5;
    localparam logic [7:0]  c_POLL_REG  = 8'h36;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [31:0] r_cnt;
    logic [1:0]  r_kind;
    logic [2:0]  r_idx;
    logic [2:0]  r_ptr;
    logic        r_req_q;
    logic [2:0]  r_rcnt;
    logic [7:0]  r_b1;
    logic [7:0]  r_b2;
    logic [7:0]  r_b3;
    logic        r_start;
    logic        r_rw;
    logic [4:0]  r_packets;
    logic [7:0]  r_data;
    logic        r_init_done;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_blob_valid;
    logic        r_strobe;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [2:0]  w_state_nxt;
    logic        w_fire;
    logic        w_gap_done;
    logic        w_ptr_done;
    logic        w_poll_done;
    logic        w_decode;
    logic        w_wr_active;
    logic        w_load_byte;
    logic        w_rw_nxt;
    logic [4:0]  w_pk_nxt;
    logic [15:0] w_tbl;
    logic [7:0]  w_byte;
    logic [9:0]  w_x_new;
    logic [9:0]  w_y_new;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_ST_PWR_WAIT;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_PWR_WAIT:  if (r_cnt == c_PWR_LAST) w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE:     if (i2c_ready) w_state_nxt = c_ST_BUSY;
            c_ST_BUSY:      if (!i2c_ready) w_state_nxt = c_ST_DONE_WAIT;
            c_ST_DONE_WAIT: begin
                if (i2c_ready) begin
                    case (r_kind)
                        c_K_INIT: w_state_nxt = c_ST_GAP;
                        c_K_PTR:  w_state_nxt = c_ST_ISSUE;
                        default:  w_state_nxt = c_ST_DECODE;
                    endcase
                end
            end
            c_ST_GAP:       if (r_cnt == c_INIT_LAST) w_state_nxt = c_ST_ISSUE;
            c_ST_DECODE:    w_state_nxt = c_ST_POLL_WAIT;
            c_ST_POLL_WAIT: if (r_cnt == c_POLL_LAST) w_state_nxt = c_ST_ISSUE;
            default:        w_state_nxt = c_ST_PWR_WAIT;
        endcase
    end

    // Output/control decode for the current state
    always_comb begin
        w_fire      = (r_state == c_ST_ISSUE) && i2c_ready;
        w_gap_done  = (r_state == c_ST_GAP) && (r_cnt == c_INIT_LAST);
        w_ptr_done  = (r_state == c_ST_DONE_WAIT) && i2c_ready && (r_kind == c_K_PTR);
        w_poll_done = (r_state == c_ST_POLL_WAIT) && (r_cnt == c_POLL_LAST);
        w_decode    = (r_state == c_ST_DECODE);
        // data_req stays high during reads, so only write transactions listen
        w_wr_active = ((r_state == c_ST_BUSY) || (r_state == c_ST_DONE_WAIT)) && !r_rw;
        w_load_byte = w_wr_active && i2c_data_req && !r_req_q;

        w_rw_nxt = 1'b0;
        w_pk_nxt = 5'd2;
        case (r_kind)
            c_K_PTR:  begin w_rw_nxt = 1'b0; w_pk_nxt = 5'd1; end
            c_K_READ: begin w_rw_nxt = 1'b1; w_pk_nxt = 5'd4; end
            default:  begin w_rw_nxt = 1'b0; w_pk_nxt = 5'd2; end
        endcase

        // Camera init table: {register, value}
        w_tbl = 16'h0000;
        case (r_idx)
            3'd0:    w_tbl = 16'h3001;
            3'd1:    w_tbl = 16'h3008;
            3'd2:    w_tbl = 16'h0690;
            3'd3:    w_tbl = 16'h08C0;
            3'd4:    w_tbl = 16'h1A40;
            3'd5:    w_tbl = 16'h3333;
            default: w_tbl = 16'h0000;
        endcase

        w_byte = 8'h00;
        if (r_kind == c_K_INIT) begin
            if (r_ptr == 3'd0)      w_byte = w_tbl[15:8];
            else if (r_ptr == 3'd1) w_byte = w_tbl[7:0];
        end else if (r_kind == c_K_PTR) begin
            if (r_ptr == 3'd0)      w_byte = c_POLL_REG;
        end

        // Blob 1: b1/b2 are X/Y low bytes, b3 carries the two MSB pairs
        w_x_new = {r_b3[5:4], r_b1};
        w_y_new = {r_b3[7:6], r_b2};
    end

    // Delay counter: restarts on every state change, runs in wait states
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 32'd0;
        end else if (r_state != w_state_nxt) begin
            r_cnt <= 32'd0;
        end else if ((r_state == c_ST_PWR_WAIT) || (r_state == c_ST_GAP) ||
                     (r_state == c_ST_POLL_WAIT)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // Transaction launch: one-cycle start pulse with rw/packets held after
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start   <= 1'b0;
            r_rw      <= 1'b0;
            r_packets <= 5'd0;
        end else begin
            r_start <= w_fire;
            if (w_fire) begin
                r_rw      <= w_rw_nxt;
                r_packets <= w_pk_nxt;
            end
        end
    end

    // Sequencing of transaction kind, init-table index and init_done flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kind      <= c_K_INIT;
            r_idx       <= 3'd0;
            r_init_done <= 1'b0;
        end else begin
            if (w_gap_done) begin
                if (r_idx == c_IDX_LAST) begin
                    r_init_done <= 1'b1;
                    r_kind      <= c_K_PTR;
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end
            if (w_ptr_done)  r_kind <= c_K_READ;
            if (w_poll_done) r_kind <= c_K_PTR;
        end
    end

    // Write-byte supply on each rising edge of data_req
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_q <= 1'b0;
            r_ptr   <= 3'd0;
            r_data  <= 8'h00;
        end else begin
            r_req_q <= i2c_data_req;
            if (w_fire) begin
                r_ptr <= 3'd0;
            end else if (w_load_byte) begin
                r_data <= w_byte;
                if (r_ptr != 3'd7) r_ptr <= r_ptr + 3'd1;
            end
        end
    end

    // Read capture; byte 0 is not needed by the decoder so it is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rcnt <= 3'd0;
            r_b1   <= 8'h00;
            r_b2   <= 8'h00;
            r_b3   <= 8'h00;
        end else if (w_fire) begin
            r_rcnt <= 3'd0;
        end else if (i2c_data_ready && (r_rcnt != 3'd4)) begin
            case (r_rcnt)
                3'd1:    r_b1 <= i2c_data_out;
                3'd2:    r_b2 <= i2c_data_out;
                3'd3:    r_b3 <= i2c_data_out;
                default: ;
            endcase
            r_rcnt <= r_rcnt + 3'd1;
        end
    end

    // Sample outputs and strobe, updated together in the decode step
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x          <= 10'd0;
            r_y          <= 10'd0;
            r_blob_valid <= 1'b0;
            r_strobe     <= 1'b0;
        end else begin
            r_strobe <= w_decode;
            if (w_decode) begin
                r_x          <= w_x_new;
                r_y          <= w_y_new;
                r_blob_valid <= (w_x_new != 10'h3FF);
            end
        end
    end

    assign i2c_addr      = I2C_ADDR;
    assign i2c_data      = r_data;
    assign i2c_packets   = r_packets;
    assign i2c_start     = r_start;
    assign i2c_rw        = r_rw;
    assign init_done     = r_init_done;
    assign x             = r_x;
    assign y             = r_y;
    assign blob_valid    = r_blob_valid;
    assign sample_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_ir_cam_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ir_cam_sequencer
//  Purpose  : Bench for ir_cam_sequencer with a behavioural I2C master/slave.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ir_cam_sequencer;

    localparam int PWR = 20;
    localparam int INI = 10;
    localparam int POL = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_data;
    logic [4:0] i2c_packets;
    logic       i2c_start;
    logic       i2c_rw;
    logic       i2c_ready = 1'b1;
    logic       i2c_data_req = 1'b0;
    logic       i2c_data_ready = 1'b0;
    logic [7:0] i2c_data_out = 8'h00;
    logic       init_done;
    logic [9:0] x;
    logic [9:0] y;
    logic       blob_valid;
    logic       sample_strobe;

    always #5 clk = ~clk;

    ir_cam_sequencer #(
        .I2C_ADDR      (7'h58),
        .POWERUP_DELAY (PWR),
        .INIT_DELAY    (INI),
        .POLL_DELAY    (POL)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .i2c_addr       (i2c_addr),
        .i2c_data       (i2c_data),
        .i2c_packets    (i2c_packets),
        .i2c_start      (i2c_start),
        .i2c_rw         (i2c_rw),
        .i2c_ready      (i2c_ready),
        .i2c_data_req   (i2c_data_req),
        .i2c_data_ready (i2c_data_ready),
        .i2c_data_out   (i2c_data_out),
        .init_done      (init_done),
        .x              (x),
        .y              (y),
        .blob_valid     (blob_valid),
        .sample_strobe  (sample_strobe)
    );

    typedef struct packed { logic rw; logic [4:0] pk; logic idn; } txn_t;
    typedef struct packed { logic [31:0] b; logic [2:0] n; } rdpat_t;
    typedef struct packed { logic [9:0] x; logic [9:0] y; logic v; } smp_t;

    txn_t       txq[$];
    logic [7:0] wq[$];
    rdpat_t     rq[$];
    smp_t       sq[$];
    int         strobe_cyc[$];

    int   n_chk = 0;
    int   n_err = 0;
    int   n_strobe = 0;
    logic m_abort = 1'b0;

    logic [15:0] tbl [6] = '{16'h3001, 16'h3008, 16'h0690, 16'h08C0, 16'h1A40, 16'h3333};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Camera byte layout: b[7:0]=byte0 ... b[31:24]=byte3
    function automatic smp_t model(input logic [31:0] b);
        smp_t s;
        s.x = {b[29:28], b[15:8]};
        s.y = {b[31:30], b[23:16]};
        s.v = (s.x != 10'h3FF);
        return s;
    endfunction

    task automatic push_init();
        for (int i = 0; i < 6; i++) begin
            txq.push_back('{rw: 1'b0, pk: 5'd2, idn: 1'b0});
            wq.push_back(tbl[i][15:8]);
            wq.push_back(tbl[i][7:0]);
        end
    endtask

    task automatic push_poll(input logic [31:0] b, input logic [2:0] n);
        txq.push_back('{rw: 1'b0, pk: 5'd1, idn: 1'b1});
        wq.push_back(8'h36);
        txq.push_back('{rw: 1'b1, pk: 5'd4, idn: 1'b1});
        rq.push_back('{b: b, n: n});
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_start"}, i2c_start, 0);
        chk({pfx, "_rw"}, i2c_rw, 0);
        chk({pfx, "_data"}, i2c_data, 0);
        chk({pfx, "_packets"}, i2c_packets, 0);
        chk({pfx, "_init_done"}, init_done, 0);
        chk({pfx, "_x"}, x, 0);
        chk({pfx, "_y"}, y, 0);
        chk({pfx, "_valid"}, blob_valid, 0);
        chk({pfx, "_strobe"}, sample_strobe, 0);
    endtask

    // Behavioural I2C master + camera slave, plus per-cycle protocol monitor
    initial begin : master
        int     st;
        int     cnt;
        int     bi;
        int     ph;
        int     cyc;
        int     t_rdy;
        int     exp_gap;
        logic   rw_l;
        logic [4:0] pk_l;
        logic   prev_start;
        logic   prev_strobe;
        rdpat_t pat;
        txn_t   t;
        smp_t   s;
        st = 0; cnt = 0; bi = 0; ph = 0; cyc = 0; t_rdy = -1; exp_gap = 0;
        rw_l = 1'b0; pk_l = 5'd0; prev_start = 1'b0; prev_strobe = 1'b0;
        pat = '0; t = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                st = 0; t_rdy = -1;
                i2c_ready = 1'b1; i2c_data_req = 1'b0; i2c_data_ready = 1'b0;
            end else begin
                if (i2c_start) begin
                    chk("start_while_ready", i2c_ready, 1);
                    chk("start_single_cycle", prev_start, 0);
                end
                if (sample_strobe) begin
                    chk("strobe_single_cycle", prev_strobe, 0);
                    if (sq.size() > 0) begin
                        s = sq.pop_front();
                        chk("x", x, s.x);
                        chk("y", y, s.y);
                        chk("blob_valid", blob_valid, s.v);
                    end else begin
                        chk("strobe_unexpected", sq.size(), 1);
                    end
                    n_strobe++;
                    strobe_cyc.push_back(cyc);
                end
                case (st)
                    0: if (i2c_start) begin
                        if (t_rdy >= 0) chk("txn_gap", cyc - t_rdy, exp_gap);
                        if (txq.size() > 0) begin
                            t = txq.pop_front();
                            chk("txn_rw", i2c_rw, t.rw);
                            chk("txn_packets", i2c_packets, t.pk);
                            chk("txn_init_done", init_done, t.idn);
                        end else begin
                            chk("txn_unexpected", txq.size(), 1);
                        end
                        rw_l = i2c_rw; pk_l = i2c_packets;
                        i2c_ready = 1'b0; cnt = 0; st = 1;
                    end
                    1: begin
                        cnt++;
                        if (cnt == 3) begin
                            bi = 0; ph = 0;
                            i2c_data_req = 1'b1;
                            if (rw_l) begin
                                if (rq.size() > 0) pat = rq.pop_front();
                                else begin
                                    chk("read_unexpected", rq.size(), 1);
                                    pat = '{b: 32'h0, n: 3'd4};
                                end
                                if (pat.n == 3'd4) sq.push_back(model(pat.b));
                                st = 3;
                            end else begin
                                st = 2;
                            end
                        end
                    end
                    2: begin
                        ph++;
                        if (ph == 1) begin
                            i2c_data_req = 1'b0;
                            if (wq.size() > 0) chk("write_byte", i2c_data, wq.pop_front());
                            else chk("write_unexpected", wq.size(), 1);
                            bi++;
                        end else if (ph == 3) begin
                            if (bi >= int'(pk_l) || bi >= 8) st = 4;
                            else begin i2c_data_req = 1'b1; ph = 0; end
                        end
                    end
                    3: begin
                        ph++;
                        if (ph == 1) begin
                            i2c_data_ready = 1'b1;
                            i2c_data_out = pat.b[8*bi +: 8];
                        end else begin
                            i2c_data_ready = 1'b0;
                            bi++; ph = 0;
                            if (bi == int'(pat.n)) begin
                                if (pat.n == 3'd4) begin
                                    chk("data_hold_in_read", i2c_data, 8'h36);
                                    st = 4;
                                end else begin
                                    m_abort = 1'b1;
                                    st = 5;
                                end
                            end
                        end
                    end
                    4: begin
                        i2c_data_req = 1'b0; i2c_data_ready = 1'b0;
                        i2c_ready = 1'b1; t_rdy = cyc;
                        if (t.rw)              exp_gap = POL + 3;
                        else if (t.pk == 5'd2) exp_gap = INI + 2;
                        else                   exp_gap = 2;
                        st = 0;
                    end
                    default: ;
                endcase
            end
            prev_start  = i2c_start;
            prev_strobe = sample_strobe;
        end
    end

    initial begin : main
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        chk("addr", i2c_addr, 7'h58);

        push_init();
        push_poll(32'h903CA500, 3'd4);
        push_poll(32'hFFFFFF00, 3'd4);
        push_poll(32'h5B341200, 3'd4);
        push_poll(32'h77665500, 3'd2);
        reset = 1'b0;

        n = 0;
        while (!i2c_start && n < PWR + 50) begin @(posedge clk); #1; n++; end
        chk("powerup_delay", n, PWR + 1);

        n = 0;
        while (n_strobe < 3 && n < 20000) begin @(posedge clk); #1; n++; end
        chk("three_polls", n_strobe, 3);
        chk("init_done_after_init", init_done, 1);
        if (strobe_cyc.size() >= 3)
            chk("strobe_spacing", strobe_cyc[2] - strobe_cyc[1], strobe_cyc[1] - strobe_cyc[0]);

        n = 0;
        while (!m_abort && n < 5000) begin @(posedge clk); #1; n++; end
        chk("abort_point_reached", m_abort, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk_reset_outputs("midread");
        txq.delete(); wq.delete(); rq.delete(); sq.delete();
        m_abort = 1'b0;

        push_init();
        push_poll(32'h6C5AC300, 3'd4);
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;
        while (!i2c_start && n < PWR + 50) begin @(posedge clk); #1; n++; end
        chk("powerup_delay_replay", n, PWR + 1);

        n = 0;
        while (n_strobe < 4 && n < 20000) begin @(posedge clk); #1; n++; end
        chk("replay_poll", n_strobe, 4);
        chk("init_done_replay", init_done, 1);
        chk("samples_consumed", sq.size(), 0);
        chk("txns_consumed", txq.size(), 0);
        chk("writes_consumed", wq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
